// File: rtl/mux3_bus_arbiter_if.sv
// mux3_bus_arbiter_if: request/data/grant bundle shared by the three requesters,
// the round-robin arbiter and the downstream consumer of the selected word.
// master = requester/consumer side, slave = arbiter side.
interface mux3_bus_arbiter_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       req;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic [2:0]       gnt;
    logic             sel1;
    logic             sel2;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;

    modport master (
        output req,
        output data0,
        output data1,
        output data2,
        input  gnt,
        input  sel1,
        input  sel2,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  req,
        input  data0,
        input  data1,
        input  data2,
        output gnt,
        output sel1,
        output sel2,
        output out_data,
        output out_valid
    );
endinterface

// File: rtl/mux3_bus_arbiter.sv
// mux3_bus_arbiter: round-robin arbiter for the shared three-input datapath mux.
// Issues a registered one-hot grant plus the mux select pair (sel1, sel2) and
// registers the selected word with a valid flag for the downstream consumer.
// Ownership is released when the owner drops its request; the next requester
// in rotation is granted on the same edge, so handoffs have no idle cycle.
// Optional build macro ARB_HOLD_LIMIT_EN: caps one owner's tenure at MAX_HOLD
// consecutive grant cycles whenever another requester is waiting.
module mux3_bus_arbiter #(
    parameter int WIDTH    = 32,
    parameter int MAX_HOLD = 8
) (
    input logic               clk,
    input logic               rst,
    mux3_bus_arbiter_if.slave bus
);

    // hold_cnt only ever needs to reach MAX_HOLD-1 (MAX_HOLD >= 2)
    localparam int                HOLD_W    = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t            state;
    logic [1:0]        owner;
    logic [1:0]        last_owner;
    logic [HOLD_W-1:0] hold_cnt;

    logic [2:0]        gnt_q;
    logic              sel1_q;
    logic              sel2_q;
    logic [WIDTH-1:0]  out_data_q;
    logic              out_valid_q;

    logic              owner_req;
    logic [WIDTH-1:0]  owner_data;
    logic [2:0]        owner_mask;
    logic [1:0]        base;
    logic [2:0]        cand_req;
    logic              pick_valid;
    logic [1:0]        pick_idx;
    logic              hold_preempt;

    // Requester index to one-hot grant vector
    function automatic logic [2:0] onehot(input logic [1:0] idx);
        logic [2:0] v;
        v = 3'b000;
        case (idx)
            2'd0:    v = 3'b001;
            2'd1:    v = 3'b010;
            default: v = 3'b100;
        endcase
        return v;
    endfunction

    // Current owner's request, data word and mask bit (all zero when idle)
    always_comb begin
        owner_req  = 1'b0;
        owner_data = '0;
        owner_mask = 3'b000;
        if (state == OWN) begin
            case (owner)
                2'd0: begin
                    owner_req  = bus.req[0];
                    owner_data = bus.data0;
                    owner_mask = 3'b001;
                end
                2'd1: begin
                    owner_req  = bus.req[1];
                    owner_data = bus.data1;
                    owner_mask = 3'b010;
                end
                default: begin
                    owner_req  = bus.req[2];
                    owner_data = bus.data2;
                    owner_mask = 3'b100;
                end
            endcase
        end
    end

    // Round-robin pick: search starts after the owner being released (or after
    // last_owner when idle); the releasing owner itself is never a candidate
    always_comb begin
        base       = (state == OWN) ? owner : last_owner;
        cand_req   = bus.req & ~owner_mask;
        pick_valid = |cand_req;
        pick_idx   = 2'd0;
        case (base)
            2'd0: begin
                if (cand_req[1])      pick_idx = 2'd1;
                else if (cand_req[2]) pick_idx = 2'd2;
                else                  pick_idx = 2'd0;
            end
            2'd1: begin
                if (cand_req[2])      pick_idx = 2'd2;
                else if (cand_req[0]) pick_idx = 2'd0;
                else                  pick_idx = 2'd1;
            end
            default: begin
                if (cand_req[0])      pick_idx = 2'd0;
                else if (cand_req[1]) pick_idx = 2'd1;
                else                  pick_idx = 2'd2;
            end
        endcase
    end

`ifdef ARB_HOLD_LIMIT_EN
    // Forced release once the owner has held for MAX_HOLD cycles and someone waits
    assign hold_preempt = (state == OWN) && owner_req && (hold_cnt == HOLD_LAST) && pick_valid;
`else
    // Without the hold limit the owner keeps the grant until it drops req
    assign hold_preempt = 1'b0;
`endif

    // Arbitration FSM with registered grant, mux selects and captured data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 2'd0;
            last_owner  <= 2'd2;
            hold_cnt    <= '0;
            gnt_q       <= 3'b000;
            sel1_q      <= 1'b0;
            sel2_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    out_valid_q <= 1'b0;
                    hold_cnt    <= '0;
                    if (pick_valid) begin
                        state  <= OWN;
                        owner  <= pick_idx;
                        gnt_q  <= onehot(pick_idx);
                        sel1_q <= (pick_idx == 2'd1);
                        sel2_q <= (pick_idx == 2'd2);
                    end else begin
                        gnt_q  <= 3'b000;
                        sel1_q <= 1'b0;
                        sel2_q <= 1'b0;
                    end
                end
                OWN: begin
                    if (owner_req) begin
                        out_data_q  <= owner_data;
                        out_valid_q <= 1'b1;
                        if (hold_preempt) begin
                            last_owner <= owner;
                            owner      <= pick_idx;
                            gnt_q      <= onehot(pick_idx);
                            sel1_q     <= (pick_idx == 2'd1);
                            sel2_q     <= (pick_idx == 2'd2);
                            hold_cnt   <= '0;
                        end else if (hold_cnt != HOLD_LAST) begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end else begin
                        last_owner  <= owner;
                        out_valid_q <= 1'b0;
                        hold_cnt    <= '0;
                        if (pick_valid) begin
                            owner  <= pick_idx;
                            gnt_q  <= onehot(pick_idx);
                            sel1_q <= (pick_idx == 2'd1);
                            sel2_q <= (pick_idx == 2'd2);
                        end else begin
                            state  <= IDLE;
                            gnt_q  <= 3'b000;
                            sel1_q <= 1'b0;
                            sel2_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt_q  <= 3'b000;
                    sel1_q <= 1'b0;
                    sel2_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel1      = sel1_q;
    assign bus.sel2      = sel2_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux3_bus_arbiter.sv
// tb_mux3_bus_arbiter: directed bench for the round-robin mux arbiter.
// Inputs change one time unit after a rising edge; outputs are checked there too.
// Expectations for the hold-limit scenario follow ARB_HOLD_LIMIT_EN when defined.
module tb_mux3_bus_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    localparam logic [31:0] D0A = 32'h1111_1111;
    localparam logic [31:0] D0B = 32'hC0C0_0000;
    localparam logic [31:0] D1  = 32'hAAAA_0001;
    localparam logic [31:0] D2  = 32'hBBBB_0002;
    localparam logic [31:0] D0C = 32'h5555_0000;
    localparam logic [31:0] D2C = 32'h7777_0002;
    localparam logic [31:0] D1C = 32'h6666_0001;

    mux3_bus_arbiter_if #(.WIDTH(32)) bus ();

    mux3_bus_arbiter #(
        .WIDTH    (32),
        .MAX_HOLD (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time bound so the run can never hang
    initial begin
        #50000;
        $display("[TB] FAIL watchdog time limit expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic [2:0] r, input logic [31:0] d0,
                                 input logic [31:0] d1, input logic [31:0] d2);
        bus.req   = r;
        bus.data0 = d0;
        bus.data1 = d1;
        bus.data2 = d2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(3'b000, 32'h0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [2:0] eg, input logic es1,
                               input logic es2, input logic [31:0] ed, input logic ev);
        checks++;
        assert (bus.gnt === eg) else begin
            errors++;
            $error("[TB] FAIL %s gnt observed %b expected %b", tag, bus.gnt, eg);
        end
        checks++;
        assert (bus.sel1 === es1) else begin
            errors++;
            $error("[TB] FAIL %s sel1 observed %b expected %b", tag, bus.sel1, es1);
        end
        checks++;
        assert (bus.sel2 === es2) else begin
            errors++;
            $error("[TB] FAIL %s sel2 observed %b expected %b", tag, bus.sel2, es2);
        end
        checks++;
        assert (bus.out_data === ed) else begin
            errors++;
            $error("[TB] FAIL %s out_data observed %h expected %h", tag, bus.out_data, ed);
        end
        checks++;
        assert (bus.out_valid === ev) else begin
            errors++;
            $error("[TB] FAIL %s out_valid observed %b expected %b", tag, bus.out_valid, ev);
        end
    endtask

    initial begin
        int          cur;
        int          prev;
        logic [2:0]  exp_gnt;
        logic [31:0] exp_data;

        checks = 0;
        errors = 0;
        rst    = 1'b1;
        applyStimulus(3'b000, 32'h0, 32'h0, 32'h0);

        // Reset state and idle with no requests
        doReset();
        checkOutput("reset", 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("idle_noreq", 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);

        // Single requester 0, three words
        applyStimulus(3'b001, D0A, 32'h0, 32'h0);
        tick();
        checkOutput("t1_grant", 3'b001, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("t1_word%0d", i), 3'b001, 1'b0, 1'b0, D0A, 1'b1);
        end
        applyStimulus(3'b000, D0A, 32'h0, 32'h0);
        tick();
        checkOutput("t1_release", 3'b000, 1'b0, 1'b0, D0A, 1'b0);
        tick();
        checkOutput("t1_idle", 3'b000, 1'b0, 1'b0, D0A, 1'b0);

        // All three requesting from reset: order 0, 1, 2, then 0 again
        doReset();
        checkOutput("t2_reset", 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(3'b111, D0B, D1, D2);
        tick();
        checkOutput("t2_g0", 3'b001, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("t2_g0w0", 3'b001, 1'b0, 1'b0, D0B, 1'b1);
        tick();
        checkOutput("t2_g0w1", 3'b001, 1'b0, 1'b0, D0B, 1'b1);
        applyStimulus(3'b110, D0B, D1, D2);
        tick();
        checkOutput("t2_g1", 3'b010, 1'b1, 1'b0, D0B, 1'b0);
        tick();
        checkOutput("t2_g1w0", 3'b010, 1'b1, 1'b0, D1, 1'b1);
        tick();
        checkOutput("t2_g1w1", 3'b010, 1'b1, 1'b0, D1, 1'b1);
        applyStimulus(3'b101, D0B, D1, D2);
        tick();
        checkOutput("t2_g2", 3'b100, 1'b0, 1'b1, D1, 1'b0);
        tick();
        checkOutput("t2_g2w0", 3'b100, 1'b0, 1'b1, D2, 1'b1);
        tick();
        checkOutput("t2_g2w1", 3'b100, 1'b0, 1'b1, D2, 1'b1);
        applyStimulus(3'b001, D0B, D1, D2);
        tick();
        checkOutput("t2_g0again", 3'b001, 1'b0, 1'b0, D2, 1'b0);
        tick();
        checkOutput("t2_g0againw", 3'b001, 1'b0, 1'b0, D0B, 1'b1);
        applyStimulus(3'b000, D0B, D1, D2);
        tick();
        checkOutput("t2_idle", 3'b000, 1'b0, 1'b0, D0B, 1'b0);

        // Owner 1 active, then asynchronous reset between edges
        applyStimulus(3'b010, D0B, D1, D2);
        tick();
        checkOutput("t3_g1", 3'b010, 1'b1, 1'b0, D0B, 1'b0);
        tick();
        checkOutput("t3_g1w", 3'b010, 1'b1, 1'b0, D1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t3_async_rst", 3'b000, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // After reset requester 0 wins; then 0 drops as 2 rises, 1 goes next
        applyStimulus(3'b011, D0B, D1, D2);
        tick();
        checkOutput("t4_g0", 3'b001, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        checkOutput("t4_g0w", 3'b001, 1'b0, 1'b0, D0B, 1'b1);
        applyStimulus(3'b110, D0B, D1, D2);
        tick();
        checkOutput("t4_g1", 3'b010, 1'b1, 1'b0, D0B, 1'b0);
        tick();
        checkOutput("t4_g1w", 3'b010, 1'b1, 1'b0, D1, 1'b1);
        applyStimulus(3'b100, D0B, D1, D2);
        tick();
        checkOutput("t4_g2", 3'b100, 1'b0, 1'b1, D1, 1'b0);
        tick();
        checkOutput("t4_g2w", 3'b100, 1'b0, 1'b1, D2, 1'b1);
        applyStimulus(3'b000, D0B, D1, D2);
        tick();
        checkOutput("t4_idle", 3'b000, 1'b0, 1'b0, D2, 1'b0);

        // req=101 held: alternates every 4 cycles with the hold limit, else stays on 0
        doReset();
        applyStimulus(3'b101, D0C, 32'h0, D2C);
        for (int i = 1; i <= 12; i++) begin
            tick();
`ifdef ARB_HOLD_LIMIT_EN
            cur  = ((((i - 1) / 4) % 2) == 0) ? 0 : 2;
            prev = ((i >= 2) && ((((i - 2) / 4) % 2) == 1)) ? 2 : 0;
`else
            cur  = 0;
            prev = 0;
`endif
            exp_gnt  = (cur == 0) ? 3'b001 : 3'b100;
            exp_data = (i == 1) ? 32'h0 : ((prev == 0) ? D0C : D2C);
            checkOutput($sformatf("t5_edge%0d", i), exp_gnt, 1'b0, (cur == 2), exp_data, (i != 1));
        end
        applyStimulus(3'b000, D0C, 32'h0, D2C);
        tick();
        checkOutput("t5_release", 3'b000, 1'b0, 1'b0, D0C, 1'b0);

        // Lone requester 1 held ten cycles: never released, valid continuous
        doReset();
        applyStimulus(3'b010, 32'h0, D1C, 32'h0);
        tick();
        checkOutput("t6_grant", 3'b010, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput($sformatf("t6_cycle%0d", i), 3'b010, 1'b1, 1'b0, D1C, 1'b1);
        end
        applyStimulus(3'b000, 32'h0, D1C, 32'h0);
        tick();
        checkOutput("t6_release", 3'b000, 1'b0, 1'b0, D1C, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
